im_burst_fetch_master: RTL and testbench

Instruction-fetch AXI4 read master, parametrised successor to the single-beat IM wrapper. Issues one INCR burst of `BURST_LEN` beats per line request, buffers returned words with their addresses in an internal FIFO, and streams them to the CPU fetch stage. It yields to the data master via `dm_busy` and supports flush, discarding buffered and in-flight data. Sits between the CPU IF stage and AXI master port M0.

---
 rtl/im_burst_fetch_master_pkg.sv | 26 ++
 rtl/im_burst_fetch_master_if.sv | 37 +++
 rtl/im_burst_fetch_master_fifo.sv | 74 +++++++
 rtl/im_burst_fetch_master.sv | 164 ++++++++++++++++
 tb/tb_im_burst_fetch_master.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_burst_fetch_master_pkg.sv
// Shared types, AXI constants and the size helper for the burst fetch master.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned log2_f(input int unsigned val);
        int unsigned res;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < val) begin
                res = unsigned'(i) + 32'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/im_burst_fetch_master_if.sv
// AXI4 read-address and read-data channels of master port M0.
interface im_burst_fetch_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();

    logic [ID_W-1:0]   ARID_M0;
    logic [ADDR_W-1:0] ARADDR_M0;
    logic [3:0]        ARLEN_M0;
    logic [2:0]        ARSIZE_M0;
    logic [1:0]        ARBURST_M0;
    logic              ARVALID_M0;
    logic              ARREADY_M0;

    logic [ID_W-1:0]   RID_M0;
    logic [DATA_W-1:0] RDATA_M0;
    logic [1:0]        RRESP_M0;
    logic              RLAST_M0;
    logic              RVALID_M0;
    logic              RREADY_M0;

    modport master (
        output ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0,
        input  ARREADY_M0,
        input  RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        output RREADY_M0
    );

    modport slave (
        input  ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0,
        output ARREADY_M0,
        output RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        input  RREADY_M0
    );

endinterface

// File: rtl/im_burst_fetch_master_fifo.sv
// Synchronous FIFO holding {address, data} fetch words; clear wins over push.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? int'(log2_f(DEPTH)) : 1,
    localparam int CNT_W = int'(log2_f(DEPTH)) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok_s  = pop_i && (count_q != CNT_W'(0));

    // Next occupancy from clear, push and pop.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = CNT_W'(0);
        end else if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            count_q <= count_d;
            if (clr_i) begin
                wr_ptr_q <= PTR_W'(0);
                rd_ptr_q <= PTR_W'(0);
            end else begin
                if (push_ok_s) begin
                    mem_q[wr_ptr_q] <= wdata_i;
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_ok_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/im_burst_fetch_master.sv
// Instruction-fetch AXI4 burst read master with word FIFO, flush and bus yield.
// Optional macro IFETCH_RRESP_CHK_EN: error responses set sticky fetch_err and drain the burst.
module im_burst_fetch_master
    import ifetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int BURST_LEN = 4,
    parameter int BUF_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   req_ready,
    input  logic                   dm_busy,
    input  logic                   flush,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [DATA_W-1:0]      inst_data,
    output logic [ADDR_W-1:0]      inst_addr,
    output logic                   fetch_err,
    im_burst_fetch_master_if.master axi
);

    localparam int BUS_BYTES_C  = DATA_W / 8;
    localparam int SIZE_C       = int'(log2_f(BUS_BYTES_C));
    localparam int LINE_BYTES_C = BURST_LEN * BUS_BYTES_C;
    localparam int CNT_W        = int'(log2_f(BUF_DEPTH)) + 1;
    localparam int ENTRY_W      = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LINE_MASK_C = ~(ADDR_W'(LINE_BYTES_C) - ADDR_W'(1));

    fetch_state_e       state_q;
    logic               arvalid_q;
    logic               rready_q;
    logic               flush_seen_q;
    logic               err_q;
    logic [ADDR_W-1:0]  araddr_q;
    logic [3:0]         beat_q;

    logic               req_fire_s;
    logic               ar_fire_s;
    logic               r_fire_s;
    logic               bad_resp_s;
    logic               push_s;
    logic               pop_s;
    logic               space_ok_s;
    logic [ADDR_W-1:0]  beat_addr_s;
    logic [ENTRY_W-1:0] head_s;
    logic [CNT_W-1:0]   count_s;
    logic               unused_s;

`ifdef IFETCH_RRESP_CHK_EN
    assign bad_resp_s = (axi.RRESP_M0 != AXI_RESP_OKAY);
`else
    assign bad_resp_s = 1'b0;
`endif

    // Space for a whole burst is reserved at acceptance so R never stalls.
    assign space_ok_s  = (CNT_W'(BUF_DEPTH) - count_s) >= CNT_W'(BURST_LEN);
    assign req_ready   = (state_q == ST_IDLE) && !flush && !dm_busy && space_ok_s && !err_q;
    assign req_fire_s  = req_valid && req_ready;
    assign ar_fire_s   = arvalid_q && axi.ARREADY_M0;
    assign r_fire_s    = rready_q && axi.RVALID_M0;
    assign beat_addr_s = araddr_q + (ADDR_W'(beat_q) << SIZE_C);
    assign push_s      = (state_q == ST_RD) && r_fire_s && !flush && !bad_resp_s;
    assign pop_s       = inst_valid && inst_ready;
    assign unused_s    = ^{axi.RID_M0, axi.RRESP_M0};

    // Burst sequencing FSM with registered AXI control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            flush_seen_q <= 1'b0;
            err_q        <= 1'b0;
            araddr_q     <= '0;
            beat_q       <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        araddr_q     <= req_addr & LINE_MASK_C;
                        beat_q       <= 4'd0;
                        flush_seen_q <= 1'b0;
                        arvalid_q    <= 1'b1;
                        state_q      <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (ar_fire_s) begin
                        arvalid_q    <= 1'b0;
                        rready_q     <= 1'b1;
                        flush_seen_q <= 1'b0;
                        state_q      <= (flush_seen_q || flush) ? ST_DRAIN : ST_RD;
                    end else if (flush) begin
                        flush_seen_q <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (r_fire_s) begin
                        beat_q <= beat_q + 4'd1;
                        if (axi.RLAST_M0) begin
                            rready_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else if (flush || bad_resp_s) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_fire_s && axi.RLAST_M0) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase

            // Error is sticky until flush; beats on a flush cycle are discarded, so they cannot set it.
            if (flush) begin
                err_q <= 1'b0;
            end else if ((state_q == ST_RD) && r_fire_s && bad_resp_s) begin
                err_q <= 1'b1;
            end
        end
    end

    ifetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (push_s),
        .wdata_i ({beat_addr_s, axi.RDATA_M0}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    assign inst_valid = (count_s != CNT_W'(0));
    assign inst_addr  = head_s[ENTRY_W-1:DATA_W];
    assign inst_data  = head_s[DATA_W-1:0];
    assign fetch_err  = err_q;

    assign axi.ARID_M0    = {ID_W{1'b0}};
    assign axi.ARADDR_M0  = araddr_q;
    assign axi.ARLEN_M0   = 4'(BURST_LEN - 1);
    assign axi.ARSIZE_M0  = 3'(SIZE_C);
    assign axi.ARBURST_M0 = AXI_BURST_INCR;
    assign axi.ARVALID_M0 = arvalid_q;
    assign axi.RREADY_M0  = rready_q;

endmodule

// File: tb/tb_im_burst_fetch_master.sv
// Directed bench for im_burst_fetch_master (BURST_LEN=4, BUF_DEPTH=8, 32-bit bus).
module tb_im_burst_fetch_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              req_valid  = 1'b0;
    logic [ADDR_W-1:0] req_addr   = '0;
    logic              dm_busy    = 1'b0;
    logic              flush      = 1'b0;
    logic              inst_ready = 1'b0;
    logic              req_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_addr;
    logic              fetch_err;

    int n_vec = 0;
    int n_bad = 0;
    int ar_hs = 0;
    int hs0   = 0;

    im_burst_fetch_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    im_burst_fetch_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .BURST_LEN(4), .BUF_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .dm_busy(dm_busy), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_addr(inst_addr),
        .fetch_err(fetch_err),
        .axi(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.ARVALID_M0 && bus.ARREADY_M0) ar_hs++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        bus.RVALID_M0 = 1'b1;
        bus.RDATA_M0  = d;
        bus.RRESP_M0  = resp;
        bus.RLAST_M0  = last;
        @(negedge clk);
        bus.RVALID_M0 = 1'b0;
        bus.RLAST_M0  = 1'b0;
        bus.RRESP_M0  = 2'b00;
    endtask

    initial begin
        bus.ARREADY_M0 = 1'b0;
        bus.RVALID_M0  = 1'b0;
        bus.RID_M0     = '0;
        bus.RDATA_M0   = '0;
        bus.RRESP_M0   = 2'b00;
        bus.RLAST_M0   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_arvalid", bus.ARVALID_M0, 64'd0);
        chk("rst_rready", bus.RREADY_M0, 64'd0);
        chk("rst_inst_valid", inst_valid, 64'd0);
        chk("rst_fetch_err", fetch_err, 64'd0);
        chk("rst_araddr", bus.ARADDR_M0, 64'd0);
        chk("rst_inst_data", inst_data, 64'd0);
        chk("rst_inst_addr", inst_addr, 64'd0);
        rst = 1'b0;

        // Basic burst, unaligned request address
        req_valid = 1'b1; req_addr = 32'h0000_0013; bus.ARREADY_M0 = 1'b1;
        #1;
        chk("t1_req_ready", req_ready, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t1_arvalid", bus.ARVALID_M0, 64'd1);
        chk("t1_araddr", bus.ARADDR_M0, 64'h10);
        chk("t1_arlen", bus.ARLEN_M0, 64'd3);
        chk("t1_arsize", bus.ARSIZE_M0, 64'd2);
        chk("t1_arburst", bus.ARBURST_M0, 64'd1);
        chk("t1_arid", bus.ARID_M0, 64'd0);
        @(negedge clk);
        chk("t1_arvalid_drop", bus.ARVALID_M0, 64'd0);
        chk("t1_rready", bus.RREADY_M0, 64'd1);
        beat(32'hA0, 2'b00, 1'b0);
        chk("t1_first_valid", inst_valid, 64'd1);
        chk("t1_first_addr", inst_addr, 64'h10);
        beat(32'hA1, 2'b00, 1'b0);
        beat(32'hA2, 2'b00, 1'b0);
        beat(32'hA3, 2'b00, 1'b1);
        chk("t1_rready_end", bus.RREADY_M0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pop_addr", inst_addr, 64'h10 + 64'(4 * i));
            chk("t1_pop_data", inst_data, 64'hA0 + 64'(i));
            inst_ready = 1'b1;
            @(negedge clk);
        end
        inst_ready = 1'b0;
        chk("t1_empty", inst_valid, 64'd0);

        // ARREADY held low for five cycles
        bus.ARREADY_M0 = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_1234;
        @(negedge clk);
        req_valid = 1'b0;
        hs0 = ar_hs;
        for (int i = 0; i < 5; i++) begin
            chk("t2_arvalid_hold", bus.ARVALID_M0, 64'd1);
            chk("t2_araddr_hold", bus.ARADDR_M0, 64'h1230);
            @(negedge clk);
        end
        bus.ARREADY_M0 = 1'b1;
        @(negedge clk);
        chk("t2_one_handshake", 64'(ar_hs), 64'(hs0 + 1));
        chk("t2_arvalid_drop", bus.ARVALID_M0, 64'd0);
        for (int i = 0; i < 4; i++) beat(32'hB0 + 32'(i), 2'b00, i == 3);
        chk("t2_head", inst_addr, 64'h1230);

        // Occupancy gate on req_ready
        req_valid = 1'b1; req_addr = 32'h0000_0047;
        #1;
        chk("t3_accept_at4", req_ready, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(32'hC0 + 32'(i), 2'b00, i == 3);
        req_valid = 1'b1; req_addr = 32'h0000_0085;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_blocked", req_ready, 64'd0);
            chk("t3_pop_addr", inst_addr, 64'h1230 + 64'(4 * i));
            inst_ready = 1'b1;
            @(negedge clk);
        end
        inst_ready = 1'b0;
        chk("t3_blocked_at5", req_ready, 64'd0);
        @(negedge clk);
        chk("t3_blocked_at5_hold", req_ready, 64'd0);
        chk("t3_no_ar", bus.ARVALID_M0, 64'd0);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("t3_ready_at4", req_ready, 64'd1);
        chk("t3_head_c0", inst_data, 64'hC0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t3_arvalid", bus.ARVALID_M0, 64'd1);
        chk("t3_araddr", bus.ARADDR_M0, 64'h80);

        // Flush after beat 2 of 4
        @(negedge clk);
        beat(32'hD0, 2'b00, 1'b0);
        beat(32'hD1, 2'b00, 1'b0);
        chk("t4_pre_flush_valid", inst_valid, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_flushed_empty", inst_valid, 64'd0);
        chk("t4_drain_rready", bus.RREADY_M0, 64'd1);
        beat(32'hD2, 2'b00, 1'b0);
        chk("t4_discard3", inst_valid, 64'd0);
        beat(32'hD3, 2'b00, 1'b1);
        chk("t4_discard4", inst_valid, 64'd0);
        chk("t4_idle_rready", bus.RREADY_M0, 64'd0);
        #1;
        chk("t4_idle_req_ready", req_ready, 64'd1);

        // dm_busy blocks acceptance in IDLE
        dm_busy = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0100;
        #1;
        chk("t5_busy_req_ready", req_ready, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_busy_no_ar", bus.ARVALID_M0, 64'd0);
        end
        dm_busy = 1'b0;
        #1;
        chk("t5_free_req_ready", req_ready, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_arvalid", bus.ARVALID_M0, 64'd1);
        chk("t5_araddr", bus.ARADDR_M0, 64'h100);

        // Error response on beat 2
        @(negedge clk);
        beat(32'hE0, 2'b00, 1'b0);
        beat(32'hE1, 2'b10, 1'b0);
`ifdef IFETCH_RRESP_CHK_EN
        chk("t6_err_set", fetch_err, 64'd1);
        beat(32'hE2, 2'b00, 1'b0);
        beat(32'hE3, 2'b00, 1'b1);
        chk("t6_rready_end", bus.RREADY_M0, 64'd0);
        chk("t6_one_word", inst_valid, 64'd1);
        chk("t6_word_addr", inst_addr, 64'h100);
        chk("t6_word_data", inst_data, 64'hE0);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("t6_only_one", inst_valid, 64'd0);
        req_valid = 1'b1; req_addr = 32'h0000_0200;
        #1;
        chk("t6_err_blocks", req_ready, 64'd0);
        @(negedge clk);
        chk("t6_no_ar", bus.ARVALID_M0, 64'd0);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t6_err_cleared", fetch_err, 64'd0);
        chk("t6_req_ready_back", req_ready, 64'd1);
`else
        chk("t6_err_tied", fetch_err, 64'd0);
        beat(32'hE2, 2'b00, 1'b0);
        beat(32'hE3, 2'b00, 1'b1);
        chk("t6_rready_end", bus.RREADY_M0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_pop_addr", inst_addr, 64'h100 + 64'(4 * i));
            chk("t6_pop_data", inst_data, 64'hE0 + 64'(i));
            inst_ready = 1'b1;
            @(negedge clk);
        end
        inst_ready = 1'b0;
        chk("t6_empty", inst_valid, 64'd0);
        chk("t6_err_still0", fetch_err, 64'd0);
`endif

        // Flush during AR, then an early-RLAST burst is drained
        bus.ARREADY_M0 = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t7_arvalid_kept", bus.ARVALID_M0, 64'd1);
        chk("t7_araddr_kept", bus.ARADDR_M0, 64'h200);
        bus.ARREADY_M0 = 1'b1;
        @(negedge clk);
        chk("t7_arvalid_drop", bus.ARVALID_M0, 64'd0);
        chk("t7_drain_rready", bus.RREADY_M0, 64'd1);
        beat(32'hF0, 2'b00, 1'b1);
        chk("t7_discarded", inst_valid, 64'd0);
        chk("t7_idle_rready", bus.RREADY_M0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
